// File: rtl/pcm_deserializer.sv
// I2S-style 16-bit stereo receiver: reassembles left/right pairs from the serial stream and
// queues them in a 2-entry FIFO behind a valid/ready handshake, with sticky error flags.
module pcm_deserializer (
  input  logic        bit_clock_in,
  input  logic        rst_active_high,
  input  logic        serial_data_in,
  input  logic        LR_select_in,
  input  logic        pcm_data_ready,
  input  logic        clear_flags,
  output logic [15:0] pcm_data_left,
  output logic [15:0] pcm_data_right,
  output logic        pcm_data_valid,
  output logic        frame_error,
  output logic        overflow
);

  typedef enum logic [1:0] {StHunt, StLeft, StRight} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_primed;
  logic        r_lr_prev;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift;
  logic [15:0] r_left_hold;
  logic [15:0] r_fifo_l [2];
  logic [15:0] r_fifo_r [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_frame_error;
  logic        r_overflow;

  logic        w_edge;
  logic        w_fall;
  logic        w_rise;
  logic        w_slot_ok;
  logic [15:0] w_word;
  logic        w_latch_left;
  logic        w_push_req;
  logic        w_err_set;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf_set;

  // The edge-cycle sample is the LSB of the slot that is ending.
  assign w_edge    = r_primed && (LR_select_in != r_lr_prev);
  assign w_fall    = w_edge && !LR_select_in;
  assign w_rise    = w_edge && LR_select_in;
  assign w_slot_ok = (r_bit_cnt == 5'd15);
  assign w_word    = {r_shift[14:0], serial_data_in};

  always_comb begin
    w_state_d    = r_state;
    w_latch_left = 1'b0;
    w_push_req   = 1'b0;
    w_err_set    = 1'b0;
    unique case (r_state)
      StHunt: begin
        if (w_fall) w_state_d = StLeft;
      end
      StLeft: begin
        if (w_rise) begin
          if (w_slot_ok) begin
            w_latch_left = 1'b1;
            w_state_d    = StRight;
          end else begin
            w_err_set = 1'b1;
            w_state_d = StHunt;
          end
        end
      end
      StRight: begin
        // A 1->0 edge always opens a fresh left slot, even after a bad right slot.
        if (w_fall) begin
          w_state_d = StLeft;
          if (w_slot_ok) w_push_req = 1'b1;
          else           w_err_set  = 1'b1;
        end
      end
      default: w_state_d = StHunt;
    endcase
  end

  assign w_full    = (r_count == 2'd2);
  assign w_pop     = pcm_data_valid && pcm_data_ready;
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_ovf_set = w_push_req && w_full && !w_pop;

  always_ff @(posedge bit_clock_in) begin
    if (rst_active_high) begin
      r_state       <= StHunt;
      r_primed      <= 1'b0;
      r_lr_prev     <= 1'b0;
      r_bit_cnt     <= 5'd0;
      r_shift       <= 16'd0;
      r_left_hold   <= 16'd0;
      r_fifo_l[0]   <= 16'd0;
      r_fifo_l[1]   <= 16'd0;
      r_fifo_r[0]   <= 16'd0;
      r_fifo_r[1]   <= 16'd0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_frame_error <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_primed  <= 1'b1;
      r_lr_prev <= LR_select_in;
      r_shift   <= w_word;
      if (w_edge)                  r_bit_cnt <= 5'd0;
      else if (r_bit_cnt != 5'd17) r_bit_cnt <= r_bit_cnt + 5'd1;
      if (w_latch_left) r_left_hold <= w_word;
      if (w_push) begin
        r_fifo_l[r_wr_ptr] <= r_left_hold;
        r_fifo_r[r_wr_ptr] <= w_word;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (!w_push && w_pop) r_count <= r_count - 2'd1;
      // Set wins over a coincident clear.
      if (w_err_set)        r_frame_error <= 1'b1;
      else if (clear_flags) r_frame_error <= 1'b0;
      if (w_ovf_set)        r_overflow <= 1'b1;
      else if (clear_flags) r_overflow <= 1'b0;
    end
  end

  assign pcm_data_left  = r_fifo_l[r_rd_ptr];
  assign pcm_data_right = r_fifo_r[r_rd_ptr];
  assign pcm_data_valid = (r_count != 2'd0);
  assign frame_error    = r_frame_error;
  assign overflow       = r_overflow;

endmodule

// File: doc/pcm_deserializer.md
# pcm_deserializer

Receive-side counterpart of the DAC serializer. It accepts a 16-bit stereo serial stream (I2S-style framing: LR select, MSB-first, one-bit delay) from an ADC or loopback path, clocked by the incoming bit clock. It reassembles each left/right pair and queues it in a 2-entry FIFO. Pairs are delivered to the mixer/tracker core over a valid/ready handshake, with sticky framing-error and overflow flags.

## Interface
- No parameters; word width fixed at 16 bits per channel, slot length fixed at 16 bit clocks.
- bit_clock_in  input  1  bit clock from ADC; all logic on rising edge; the only clock.
- rst_active_high  input  1  synchronous, active-high reset.
- serial_data_in  input  1  serial PCM, MSB first.
- LR_select_in  input  1  channel select, 0=Left, 1=Right.
- pcm_data_ready  input  1  consumer accepts head pair when high with pcm_data_valid.
- clear_flags  input  1  one-cycle pulse clears frame_error and overflow.
- pcm_data_left  output  16  left sample of FIFO head.
- pcm_data_right  output  16  right sample of FIFO head.
- pcm_data_valid  output  1  FIFO non-empty.
- frame_error  output  1  sticky; slot length violation seen.
- overflow  output  1  sticky; completed pair dropped because FIFO full.

## Operation
- Every rising edge: sample serial_data_in and LR_select_in; lr_prev holds previous LR sample; primed flag set after first post-reset sample. Edges are only recognized when primed.
- Framing: LR transition seen at edge cycle t; samples at t+1..t+16 are the new channel's bits MSB..LSB. The t+16 sample coincides with the next LR transition and is the LSB of the ending slot.
- Bit counter: reset to 0 at each LR transition (edge-cycle sample excluded from the new slot). Incremented per non-edge sample, saturating at 17. At an edge, the ending slot is valid iff counter==15 (15 prior samples + edge-cycle LSB = 16).
- Shift register: 16 bits, shifts left inserting serial_data_in every cycle. At a valid slot end, the word is {shift[14:0], serial_data_in}.
- FSM states:
  - HUNT: wait for LR 1->0 transition, then go to LEFT. No words are stored and no errors are raised in HUNT.
  - LEFT: at the 0->1 transition, if the slot is valid, latch left_hold and go to RIGHT; otherwise set frame_error and go to HUNT.
  - RIGHT: at the 1->0 transition, if the slot is valid, push {left_hold, right word} into the FIFO and go to LEFT; otherwise set frame_error and go to LEFT. The 1->0 edge is itself a valid left-slot start.
- FIFO: 2 entries, pointer/count based.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - A push while full with no pop drops the new pair and sets overflow; FIFO contents are unchanged.
- Outputs are driven from the FIFO head register; data is stable while pcm_data_valid=1 and pcm_data_ready=0.
- clear_flags clears both flags. If a flag-setting event occurs in the same cycle as clear_flags, set wins.
- Reset (synchronous): state=HUNT, primed=0, counter=0, shift=0, left_hold=0, FIFO empty. All outputs 0: pcm_data_left=0, pcm_data_right=0, pcm_data_valid=0, frame_error=0, overflow=0.
- Reset mid-slot discards partial words and any FIFO contents. Receive resumes at the next LR 1->0 transition.

## Timing
- The pair is pushed on the edge that samples the right LSB (cycle E). pcm_data_valid=1 from E+1 if the FIFO was empty.
- Handshake: a pop occurs on the edge where pcm_data_valid && pcm_data_ready. The next head, or valid=0, is visible on the following cycle.
- Minimum lock time after reset: first 1->0 LR transition + 32 bit clocks + 1 cycle to first valid.
- Steady state: one pair per 32 bit clocks. Consumer must pop within 64 clocks of a fill to avoid overflow.
- Flags assert the cycle after the offending edge.

## Test plan
- Nominal: after reset, hold LR=1 for 3 clocks. Then send frames L=0xA5C3, R=0x1234, then L=0x8000, R=0x7FFF, with ready=1. Expect valid pulses 1 cycle after each right LSB, carrying exactly these pairs, with frame_error=0 and overflow=0.
- Short slot: a left slot with LR returning high after 12 bits. Expect frame_error=1 the next cycle, no push, and FSM in HUNT. The next correct frame L=0x0F0F, R=0xF0F0 is delivered. clear_flags then drops frame_error to 0.
- Long right slot (20 bits) -> frame_error=1, pair dropped, FSM in LEFT. The following frame L=0x1111, R=0x2222 is received correctly.
- Backpressure: ready=0 for 3 frames (0x0001/0x0002, 0x0003/0x0004, 0x0005/0x0006). FIFO holds the first two and overflow=1. Raising ready yields 0x0001/0x0002 then 0x0003/0x0004, then valid=0.
- Full with simultaneous push/pop: FIFO full, ready=1 on the cycle a third pair completes. Expect no overflow, and the output order is preserved.
- Reset mid-left-slot after 8 bits: all outputs 0 the next cycle, and no error when resuming at the next 1->0 LR transition.
